// File: rtl/rca_pkg.sv
// Shared types and defaults for the result RAM read path.
// The FSM encoding is shared so the top and any debug taps agree on state values.
package rca_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/result_ram_reader_if.sv
// Handshake bundle between the result RAM reader, the result RAM and the downstream consumer.
interface result_ram_reader_if #(
  parameter int DATA_W = rca_pkg::DATA_W_DEF,
  parameter int ADDR_W = rca_pkg::ADDR_W_DEF
);
  logic              done_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              drained;

  modport master (
    input  done_in, rd_data, out_ready,
    output rd_en, rd_addr, out_valid, out_data, out_last, busy, drained
  );

  modport slave (
    output done_in, rd_data, out_ready,
    input  rd_en, rd_addr, out_valid, out_data, out_last, busy, drained
  );
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry output buffer holding {last, data}; head is visible on dout whenever count != 0.
// Simultaneous push and pop keep occupancy unchanged; pop on an empty buffer is ignored.
module result_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         pop_ok;
  logic [1:0]   count_d;

  assign pop_ok  = pop && (count_q != 2'd0);
  assign count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clr) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // The reader's credit check guarantees a free slot for every returning read.
  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(!clr && push && !pop_ok && count_q == 2'd2));

endmodule

// File: rtl/result_ram_reader.sv
// Drains the result RAM after the controller's done pulse and streams words out valid/ready.
// Reads are only issued when a buffer slot is guaranteed for the returning word.
module result_ram_reader
  import rca_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_WORDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  result_ram_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              busy_q;
  logic              drained_q;

  logic              fifo_clr;
  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_dout;
  logic [1:0]        occ_after_pop;
  logic              credit_ok;
  logic              rd_en;
  logic              drain_done;

  assign fifo_pop      = bus.out_valid && bus.out_ready;
  assign fifo_clr      = (state_q == IDLE) && bus.done_in;
  assign occ_after_pop = fifo_count - {1'b0, fifo_pop};
  // Buffered words plus the one possibly returning from the RAM must leave room for another.
  assign credit_ok     = ({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2;
  assign rd_en         = (state_q == READ) && credit_ok;
  assign drain_done    = (occ_after_pop == 2'd0) && !inflight_q;
  assign addr_d        = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;

  result_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (inflight_q),
    .pop   (fifo_pop),
    .din   ({inflight_last_q, bus.rd_data}),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      drained_q       <= 1'b0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= (addr_q == LAST_ADDR);
      case (state_q)
        IDLE: begin
          drained_q <= 1'b0;
          if (bus.done_in) begin
            state_q <= READ;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          if (rd_en) begin
            if (addr_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_d;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q   <= FINISH;
            drained_q <= 1'b1;
          end
        end
        FINISH: begin
          state_q   <= IDLE;
          drained_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = (state_q == READ) ? addr_q : '0;
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = fifo_dout[DATA_W-1:0];
  assign bus.out_last  = fifo_dout[DATA_W];
  assign bus.busy      = busy_q;
  assign bus.drained   = drained_q;

endmodule
